// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared types and helpers for the rr_mux selection datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

  // Selection policy applied by the multiplexer.
  typedef enum logic {
    MUX_RR    = 1'b0,
    MUX_FIXED = 1'b1
  } mux_mode_t;

  // Occupancy of the output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Next channel index with wrap-around modulo n.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_pick
//  Purpose  : Rotating-priority picker. Searches the eligible vector starting
//             at ptr+1 (wrapping) and returns the first hit as one-hot and
//             encoded index, plus an any-hit flag.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick
  import mux_pkg::*;
#(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] index,
  output logic          any
);

  // Walk N positions after ptr; the first eligible position wins.
  always_comb begin
    int idx;
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = int'(ptr);
    for (int k = 0; k < N; k++) begin
      idx = next_idx(idx, N);
      if (!any && eligible[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        index      = SW'(idx);
      end
    end
  end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux
//  Purpose  : N-channel, W-bit multiplexer with registered output and
//             valid/ready handshakes. Selects round-robin or by fixed index
//             and holds the chosen word until the consumer accepts it.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mux
  import mux_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int W  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel_fixed,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  out_state_t    r_state;
  out_state_t    w_state_nxt;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_ptr;

  mux_mode_t     w_mode;
  logic          w_ld;
  logic [N-1:0]  w_eligible;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_idx;
  logic          w_any;
  logic          w_xfer;
  logic [W-1:0]  w_word;

  assign w_mode = mux_mode_t'(mode);

  // The register can accept a word when empty or when it drains this cycle.
  assign w_ld = (r_state == ST_EMPTY) || out_ready;

  // Fixed mode narrows eligibility to sel_fixed; an out-of-range index
  // matches no channel, so nothing becomes eligible.
  always_comb begin
    w_eligible = '0;
    if (w_mode == MUX_RR) begin
      w_eligible = in_valid;
    end else begin
      for (int i = 0; i < N; i++) begin
        w_eligible[i] = in_valid[i] && (sel_fixed == SW'(i));
      end
    end
  end

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .index    (w_idx),
    .any      (w_any)
  );

  // Grants are suppressed during reset so no producer sees a false accept.
  assign in_ready = (w_ld && !rst) ? w_grant : '0;
  assign w_xfer   = w_ld && w_any && !rst;

  // Route the granted channel's word to the output register input.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_word = in_data[i*W +: W];
      end
    end
  end

  // Occupancy next-state: reload or empty whenever a load slot is open.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ld) begin
      w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data, source index and rotation pointer update only on a transfer;
  // an emptying cycle leaves the stale word and index in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_sel  <= '0;
      r_ptr  <= SW'(N - 1);
    end else if (w_xfer) begin
      r_data <= w_word;
      r_sel  <= w_idx;
      r_ptr  <= w_idx;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule : rr_mux
`default_nettype wire

// File: tb/tb_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux
//  Purpose  : Directed self-checking bench for rr_mux with N = 4, W = 8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel_fixed;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  rr_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel_fixed (sel_fixed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered outputs.
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel_fixed = 2'd0;
    in_valid  = 4'b1111;
    in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    tick();
    chk("rst_ready0", 32'(in_ready), 32'h0);
    tick();
    chk("rst_ready1", 32'(in_ready), 32'h0);
    chk_out("rst_out", 1'b0, 8'h00, 2'd0);

    // Round-robin sequence 0,1,2,3,0.
    rst = 1'b0;
    #1;
    chk("rr_ready0", 32'(in_ready), 32'b0001);
    tick(); chk_out("rr0", 1'b1, 8'hA0, 2'd0);
    chk("rr_ready1", 32'(in_ready), 32'b0010);
    tick(); chk_out("rr1", 1'b1, 8'hB1, 2'd1);
    chk("rr_ready2", 32'(in_ready), 32'b0100);
    tick(); chk_out("rr2", 1'b1, 8'hC2, 2'd2);
    chk("rr_ready3", 32'(in_ready), 32'b1000);
    tick(); chk_out("rr3", 1'b1, 8'hD3, 2'd3);
    tick(); chk_out("rr4", 1'b1, 8'hA0, 2'd0);

    // Bring ptr to 3, then sparse requests with wrap.
    in_valid = 4'b1000;
    tick(); chk_out("sp_pre", 1'b1, 8'hD3, 2'd3);
    in_valid = 4'b0110;
    #1;
    chk("sp_ready1", 32'(in_ready), 32'b0010);
    tick(); chk_out("sp1", 1'b1, 8'hB1, 2'd1);
    chk("sp_ready2", 32'(in_ready), 32'b0100);
    tick(); chk_out("sp2", 1'b1, 8'hC2, 2'd2);
    in_valid = 4'b0001;
    #1;
    chk("sp_ready0", 32'(in_ready), 32'b0001);
    tick(); chk_out("sp0", 1'b1, 8'hA0, 2'd0);

    // Backpressure: load B1, then stall five cycles.
    in_valid = 4'b1111;
    tick(); chk_out("bp_load", 1'b1, 8'hB1, 2'd1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'h0);
      tick(); chk_out("bp_hold", 1'b1, 8'hB1, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    tick(); chk_out("bp_reload", 1'b1, 8'hC2, 2'd2);

    // Fixed select on channel 2.
    mode      = 1'b1;
    sel_fixed = 2'd2;
    #1;
    chk("fx_ready_a", 32'(in_ready), 32'b0100);
    tick(); chk_out("fx_a", 1'b1, 8'hC2, 2'd2);
    chk("fx_ready_b", 32'(in_ready), 32'b0100);
    tick(); chk_out("fx_b", 1'b1, 8'hC2, 2'd2);
    in_valid = 4'b1011;
    #1;
    chk("fx_ready_none", 32'(in_ready), 32'h0);
    tick(); chk_out("fx_empty", 1'b0, 8'hC2, 2'd2);
    // Back to round-robin resumes after channel 2.
    mode     = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("fx_rr_ready", 32'(in_ready), 32'b1000);
    tick(); chk_out("fx_rr", 1'b1, 8'hD3, 2'd3);

    // Mid-stream reset while holding C2.
    in_valid = 4'b0100;
    tick(); chk_out("mr_load", 1'b1, 8'hC2, 2'd2);
    rst      = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("mr_ready_rst", 32'(in_ready), 32'h0);
    tick(); chk_out("mr_after", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    #1;
    chk("mr_ready0", 32'(in_ready), 32'b0001);
    tick(); chk_out("mr_first", 1'b1, 8'hA0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux
`default_nettype wire
